prime_test_scheduler: RTL

// Shares one iterative trial-division prime-test engine among NUM_REQ requesters.

---
 rtl/prime_test_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/prime_test_scheduler.sv
// Round-robin front end sharing one trial-division prime-test engine among NUM_REQ requesters.
// The engine tests one divisor per cycle and returns each result tagged with the requester index.
module prime_test_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_number,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [WIDTH-1:0]           rsp_number,
    output logic                       rsp_is_prime,
    output logic [15:0]                prime_count,
    output logic                       busy
);

    // state | meaning
    // IDLE  | waiting for any req_valid; round-robin grant from ptr+1
    // TEST  | one trial divisor per cycle until a decision is reached
    // RESP  | result held on rsp_* until rsp_ready handshake
    typedef enum logic [1:0] {IDLE, TEST, RESP} state_t;

    localparam int SQW = 2*WIDTH + 2;

    state_t             state;
    state_t             state_next;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id;
    logic [WIDTH-1:0]   num;
    logic [WIDTH:0]     divisor;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic [WIDTH-1:0]   grant_number;
    logic               grant_found;

    logic [SQW-1:0]     div_sq;
    logic [WIDTH:0]     remainder;
    logic               is_small;
    logic               sq_over;
    logic               divides;
    logic               decide;
    logic               result;
    logic               accept;
    logic               handshake;

    // Two passes: indices above ptr first, then wrap around to ptr itself.
    always_comb begin
        grant        = '0;
        grant_id     = '0;
        grant_number = '0;
        grant_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) > ptr)) begin
                grant_found  = 1'b1;
                grant[i]     = 1'b1;
                grant_id     = IDW'(i);
                grant_number = req_number[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) <= ptr)) begin
                grant_found  = 1'b1;
                grant[i]     = 1'b1;
                grant_id     = IDW'(i);
                grant_number = req_number[i*WIDTH +: WIDTH];
            end
        end
    end

    assign div_sq    = SQW'(divisor) * SQW'(divisor);
    assign remainder = {1'b0, num} % divisor;
    assign is_small  = (num < WIDTH'(2));
    assign sq_over   = (div_sq > SQW'(num));
    assign divides   = (remainder == '0);
    assign decide    = (state == TEST) && (is_small || sq_over || divides);
    assign result    = !is_small && sq_over;
    assign accept    = (state == IDLE) && grant_found;
    assign handshake = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_found) state_next = TEST;
            TEST:    if (decide)      state_next = RESP;
            RESP:    if (handshake)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Grant strobe is masked while reset is asserted so all outputs read 0 in reset.
    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if ((state == IDLE) && rst_n) begin
            req_ready = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= IDW'(NUM_REQ - 1);
            id           <= '0;
            num          <= '0;
            divisor      <= (WIDTH+1)'(2);
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_number   <= '0;
            rsp_is_prime <= 1'b0;
            prime_count  <= '0;
        end else begin
            if (accept) begin
                ptr     <= grant_id;
                id      <= grant_id;
                num     <= grant_number;
                divisor <= (WIDTH+1)'(2);
            end else if ((state == TEST) && !decide) begin
                divisor <= divisor + (WIDTH+1)'(1);
            end

            if (decide) begin
                rsp_valid    <= 1'b1;
                rsp_id       <= id;
                rsp_number   <= num;
                rsp_is_prime <= result;
            end else if (handshake) begin
                rsp_valid    <= 1'b0;
            end

            if (handshake && rsp_is_prime && (prime_count != 16'hFFFF)) begin
                prime_count <= prime_count + 16'd1;
            end
        end
    end

endmodule
